// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - BCD stopwatch with start/stop/lap/clear control
//
// Counts tenths, seconds and minutes (00:00.0 .. 59:59.9) from the divider's
// 10 Hz square wave. Two pre-debounced buttons drive an IDLE/RUN/PAUSE/LAP FSM.
//
// Ports:
//   clk        system clock (same as the frequency divider)
//   rst        asynchronous active-high reset
//   tick_10    10 Hz square wave; each rising edge adds 0.1 s while running
//   btn_ss     start/stop button, acts on rising edge
//   btn_lc     lap/clear button, acts on rising edge
//   d_min_t    minutes tens digit   (0-5)
//   d_min_u    minutes units digit  (0-9)
//   d_sec_t    seconds tens digit   (0-5)
//   d_sec_u    seconds units digit  (0-9)
//   d_ds       tenths digit         (0-9)
//   running    high in RUN or LAP
//   lap_active high in LAP (display frozen on the lap register)
//   wrap       one-cycle pulse after rollover 59:59.9 -> 00:00.0
module stopwatch_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_10,
  input  logic       btn_ss,
  input  logic       btn_lc,
  output logic [2:0] d_min_t,
  output logic [3:0] d_min_u,
  output logic [2:0] d_sec_t,
  output logic [3:0] d_sec_u,
  output logic [3:0] d_ds,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] tick_sync_q, ss_sync_q, lc_sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   tick_hist_q, ss_hist_q, lc_hist_q;
  logic                   tick_arm_q, ss_arm_q, lc_arm_q;
  logic                   tick_s, ss_s, lc_s, filled;
  logic                   tick_p, ss_p, lc_p;

  assign tick_s = tick_sync_q[SYNC_STAGES-1];
  assign ss_s   = ss_sync_q[SYNC_STAGES-1];
  assign lc_s   = lc_sync_q[SYNC_STAGES-1];

  // fill_q marks when the synchronizer outputs carry real input samples rather
  // than reset zeros. An edge detector is only armed once its input has been
  // genuinely observed low, so a level already high at reset release is ignored.
  assign filled = fill_q[SYNC_STAGES-1];

  assign tick_p = tick_s & ~tick_hist_q & tick_arm_q;
  assign ss_p   = ss_s   & ~ss_hist_q   & ss_arm_q;
  assign lc_p   = lc_s   & ~lc_hist_q   & lc_arm_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_sync_q <= '0;
      ss_sync_q   <= '0;
      lc_sync_q   <= '0;
      fill_q      <= '0;
      tick_hist_q <= 1'b0;
      ss_hist_q   <= 1'b0;
      lc_hist_q   <= 1'b0;
      tick_arm_q  <= 1'b0;
      ss_arm_q    <= 1'b0;
      lc_arm_q    <= 1'b0;
    end else begin
      tick_sync_q <= {tick_sync_q[SYNC_STAGES-2:0], tick_10};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], btn_ss};
      lc_sync_q   <= {lc_sync_q[SYNC_STAGES-2:0], btn_lc};
      fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      tick_hist_q <= tick_s;
      ss_hist_q   <= ss_s;
      lc_hist_q   <= lc_s;
      if (filled && !tick_s) tick_arm_q <= 1'b1;
      if (filled && !ss_s)   ss_arm_q   <= 1'b1;
      if (filled && !lc_s)   lc_arm_q   <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   lap_load, clr, count_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ss_p always wins over lc_p when both arrive in the same cycle.
  always_comb begin
    state_d  = state_q;
    lap_load = 1'b0;
    clr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ss_p) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_p) begin
          state_d = S_PAUSE;
        end else if (lc_p) begin
          state_d  = S_LAP;
          lap_load = 1'b1;
        end
      end
      S_LAP: begin
        if (ss_p)      state_d = S_PAUSE;
        else if (lc_p) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss_p) begin
          state_d = S_RUN;
        end else if (lc_p) begin
          state_d = S_IDLE;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counting follows the registered state, so a tick coinciding with
  // RUN->PAUSE still counts and one coinciding with PAUSE->RUN does not.
  assign count_en = tick_p && (state_q == S_RUN || state_q == S_LAP);

  // ---------------------------------------------------------------------------
  // Live BCD counter
  // ---------------------------------------------------------------------------
  logic [2:0] min_t_q, min_t_d, sec_t_q, sec_t_d;
  logic [3:0] min_u_q, min_u_d, sec_u_q, sec_u_d, ds_q, ds_d;
  logic       wrap_q, wrap_d;

  always_comb begin
    ds_d    = ds_q;
    sec_u_d = sec_u_q;
    sec_t_d = sec_t_q;
    min_u_d = min_u_q;
    min_t_d = min_t_q;
    wrap_d  = 1'b0;
    if (clr) begin
      ds_d    = '0;
      sec_u_d = '0;
      sec_t_d = '0;
      min_u_d = '0;
      min_t_d = '0;
    end else if (count_en) begin
      if (ds_q != 4'd9) begin
        ds_d = ds_q + 4'd1;
      end else begin
        ds_d = '0;
        if (sec_u_q != 4'd9) begin
          sec_u_d = sec_u_q + 4'd1;
        end else begin
          sec_u_d = '0;
          if (sec_t_q != 3'd5) begin
            sec_t_d = sec_t_q + 3'd1;
          end else begin
            sec_t_d = '0;
            if (min_u_q != 4'd9) begin
              min_u_d = min_u_q + 4'd1;
            end else begin
              min_u_d = '0;
              if (min_t_q != 3'd5) begin
                min_t_d = min_t_q + 3'd1;
              end else begin
                min_t_d = '0;
                wrap_d  = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ds_q    <= '0;
      sec_u_q <= '0;
      sec_t_q <= '0;
      min_u_q <= '0;
      min_t_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      ds_q    <= ds_d;
      sec_u_q <= sec_u_d;
      sec_t_q <= sec_t_d;
      min_u_q <= min_u_d;
      min_t_q <= min_t_d;
      wrap_q  <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lap register: captures the pre-increment live value on RUN->LAP
  // ---------------------------------------------------------------------------
  logic [2:0] lap_min_t_q, lap_sec_t_q;
  logic [3:0] lap_min_u_q, lap_sec_u_q, lap_ds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_ds_q    <= '0;
      lap_sec_u_q <= '0;
      lap_sec_t_q <= '0;
      lap_min_u_q <= '0;
      lap_min_t_q <= '0;
    end else if (clr) begin
      lap_ds_q    <= '0;
      lap_sec_u_q <= '0;
      lap_sec_t_q <= '0;
      lap_min_u_q <= '0;
      lap_min_t_q <= '0;
    end else if (lap_load) begin
      lap_ds_q    <= ds_q;
      lap_sec_u_q <= sec_u_q;
      lap_sec_t_q <= sec_t_q;
      lap_min_u_q <= min_u_q;
      lap_min_t_q <= min_t_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign running    = (state_q == S_RUN) || (state_q == S_LAP);
  assign lap_active = (state_q == S_LAP);
  assign wrap       = wrap_q;

  assign d_min_t = lap_active ? lap_min_t_q : min_t_q;
  assign d_min_u = lap_active ? lap_min_u_q : min_u_q;
  assign d_sec_t = lap_active ? lap_sec_t_q : sec_t_q;
  assign d_sec_u = lap_active ? lap_sec_u_q : sec_u_q;
  assign d_ds    = lap_active ? lap_ds_q    : ds_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_10 = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lc = 1'b0;
  logic [2:0] d_min_t, d_sec_t;
  logic [3:0] d_min_u, d_sec_u, d_ds;
  logic       running, lap_active, wrap;

  stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_10    (tick_10),
    .btn_ss     (btn_ss),
    .btn_lc     (btn_lc),
    .d_min_t    (d_min_t),
    .d_min_u    (d_min_u),
    .d_sec_t    (d_sec_t),
    .d_sec_u    (d_sec_u),
    .d_ds       (d_ds),
    .running    (running),
    .lap_active (lap_active),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_LAP   = 3;

  int n_assert = 0;
  int n_fail   = 0;
  int m_state  = M_IDLE;
  int m_t      = 0;
  int m_lap    = 0;
  int wrap_cycles = 0;
  int w0;

  logic [17:0] disp;
  assign disp = {d_min_t, d_min_u, d_sec_t, d_sec_u, d_ds};

  always @(negedge clk) if (!rst && wrap) wrap_cycles = wrap_cycles + 1;

  function automatic logic [17:0] bcd_of(input int t);
    int m, s;
    m = t / 600;
    s = (t / 10) % 60;
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic logic [17:0] exp_disp();
    return bcd_of(m_state == M_LAP ? m_lap : m_t);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, " display"}, 32'(disp), 32'(exp_disp()));
    chk({tag, " running"}, 32'(running), 32'(m_state == M_RUN || m_state == M_LAP));
    chk({tag, " lap_active"}, 32'(lap_active), 32'(m_state == M_LAP));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick(input int hi, input int lo);
    tick_10 = 1'b1;
    cycles(hi);
    tick_10 = 1'b0;
    cycles(lo);
    if (m_state == M_RUN || m_state == M_LAP) m_t = (m_t + 1) % 36000;
  endtask

  task automatic rtick();
    tick(int'($urandom_range(3, 6)), int'($urandom_range(3, 6)));
  endtask

  // Reference behaviour of one button event (ss has priority over lc).
  task automatic press(input bit ss, input bit lc);
    btn_ss = ss;
    btn_lc = lc;
    cycles(int'($urandom_range(2, 6)));
    btn_ss = 1'b0;
    btn_lc = 1'b0;
    cycles(4);
    if (ss) begin
      case (m_state)
        M_IDLE:  m_state = M_RUN;
        M_RUN:   m_state = M_PAUSE;
        M_LAP:   m_state = M_PAUSE;
        default: m_state = M_RUN;
      endcase
    end else if (lc) begin
      case (m_state)
        M_RUN:   begin m_lap = m_t; m_state = M_LAP; end
        M_LAP:   m_state = M_RUN;
        M_PAUSE: begin m_t = 0; m_lap = 0; m_state = M_IDLE; end
        default: ;
      endcase
    end
  endtask

  initial begin
    // Reset values
    cycles(3);
    chk("reset display", 32'(disp), 32'd0);
    chk("reset running", 32'(running), 32'd0);
    chk("reset lap_active", 32'(lap_active), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);

    // Inputs already high at reset release must not act
    tick_10 = 1'b1;
    btn_ss  = 1'b1;
    cycles(1);
    rst = 1'b0;
    cycles(10);
    chk_all("held at release");
    btn_ss  = 1'b0;
    tick_10 = 1'b0;
    cycles(6);
    chk_all("after release low");

    // Idle: ticks and lap/clear have no effect
    for (int i = 0; i < 25; i++) rtick();
    chk_all("idle 25 ticks");
    press(0, 1);
    chk_all("idle lc");

    // Start and count 2.5 s
    press(1, 0);
    chk_all("start");
    for (int i = 0; i < 25; i++) rtick();
    chk_all("run 25 ticks");
    chk("run 00:02.5", 32'(disp), 32'(bcd_of(25)));

    // Latency: three edges from input rise to count change, held level counts once
    tick_10 = 1'b1;
    @(negedge clk);
    chk("latency edge1", 32'(disp), 32'(exp_disp()));
    @(negedge clk);
    chk("latency edge2", 32'(disp), 32'(exp_disp()));
    @(negedge clk);
    m_t = m_t + 1;
    chk("latency edge3", 32'(disp), 32'(exp_disp()));
    cycles(20);
    chk("held tick single", 32'(disp), 32'(exp_disp()));
    tick_10 = 1'b0;
    cycles(4);

    // Lap at 00:12.3
    while (m_t < 123) rtick();
    chk("at 00:12.3", 32'(disp), 32'(bcd_of(123)));
    press(0, 1);
    chk_all("lap enter");
    for (int i = 0; i < 10; i++) rtick();
    chk_all("lap frozen");
    chk("lap holds 00:12.3", 32'(disp), 32'(bcd_of(123)));
    press(0, 1);
    chk_all("lap release");
    chk("release 00:13.3", 32'(disp), 32'(bcd_of(133)));

    // Pause, simultaneous buttons, clear
    press(1, 0);
    chk_all("pause");
    for (int i = 0; i < 5; i++) rtick();
    chk_all("pause 5 ticks");
    press(1, 1);
    chk_all("both from pause");
    rtick();
    rtick();
    chk_all("run after both");
    press(1, 0);
    press(0, 1);
    chk_all("clear");
    chk("clear 00:00.0", 32'(disp), 32'd0);

    // Randomized walk against the reference model
    for (int i = 0; i < 80; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 6)       rtick();
      else if (r == 6) press(1, 0);
      else if (r == 7) press(0, 1);
      else             press(1, 1);
      chk_all("random");
    end

    // Back to IDLE, then start from 00:00.0 for the wrap run
    for (int i = 0; i < 4 && m_state != M_IDLE; i++) begin
      if (m_state == M_PAUSE) press(0, 1);
      else                    press(1, 0);
    end
    chk_all("to idle");
    press(1, 0);
    w0 = wrap_cycles;
    for (int i = 0; i < 35999; i++) tick(3, 3);
    chk("59:59.9", 32'(disp), 32'(bcd_of(35999)));
    chk("no early wrap", 32'(wrap_cycles - w0), 32'd0);
    tick(3, 3);
    chk("wrapped 00:00.0", 32'(disp), 32'd0);
    chk("wrap one cycle", 32'(wrap_cycles - w0), 32'd1);
    for (int i = 0; i < 3; i++) rtick();
    chk_all("after wrap");

    // Asynchronous reset in LAP
    press(0, 1);
    for (int i = 0; i < 3; i++) rtick();
    chk_all("lap before reset");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async display", 32'(disp), 32'd0);
    chk("async running", 32'(running), 32'd0);
    chk("async lap_active", 32'(lap_active), 32'd0);
    chk("async wrap", 32'(wrap), 32'd0);
    m_state = M_IDLE;
    m_t     = 0;
    m_lap   = 0;
    cycles(3);
    rst = 1'b0;
    cycles(6);
    chk_all("idle after reset");
    press(0, 1);
    chk_all("lc after reset");
    press(1, 0);
    for (int i = 0; i < 3; i++) rtick();
    chk_all("restart after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller that sits directly downstream of the lab frequency divider. It consumes the divider's 10 Hz square wave as its time base and counts tenths of a second, seconds and minutes in BCD, from 00:00.0 to 59:59.9. Two push-buttons drive a start/stop/lap/clear state machine. The BCD digit outputs feed the 7-segment display driver.

## Interface
- SYNC_STAGES, 2, synchronizer depth for tick_10 and both buttons; minimum 2
- clk  in  1  system clock, same clock that drives the frequency divider
- rst  in  1  reset, asynchronous, active-high
- tick_10  in  1  10 Hz square wave from the divider; each rising edge advances the count by 0.1 s
- btn_ss  in  1  start/stop button, active-high level; acts on its rising edge only
- btn_lc  in  1  lap/clear button, active-high level; acts on its rising edge only
- d_min_t  out  3  minutes tens digit, 0–5
- d_min_u  out  4  minutes units digit, 0–9
- d_sec_t  out  3  seconds tens digit, 0–5
- d_sec_u  out  4  seconds units digit, 0–9
- d_ds  out  4  tenths digit, 0–9
- running  out  1  high in RUN or LAP
- lap_active  out  1  high in LAP; the display is frozen
- wrap  out  1  one-cycle pulse when the count rolls over from 59:59.9 to 00:00.0

## Operation
- Input conditioning
  - tick_10, btn_ss and btn_lc each pass through a SYNC_STAGES flop chain, followed by one history flop.
  - Each produces a one-cycle pulse: sync_out & ~history.
  - The pulses are tick_p, ss_p and lc_p.
- Live counter: five BCD digits. An increment happens when tick_p=1 and the current state is RUN or LAP.
  - ds: 9 → 0, carry.
  - sec_u: 9 → 0, carry.
  - sec_t: 5 → 0, carry.
  - min_u: 9 → 0, carry.
  - min_t: 5 → 0, and wrap pulses.
  - Digits never take illegal BCD values.
- Lap register: five digits. Loaded with the live counter value held before the clock edge, on the RUN→LAP transition.
  - If tick_p is high in the same cycle, the lap register takes the pre-increment value and the live counter still increments.
- Display outputs are combinational: lap register when the state is LAP, live counter otherwise.
- FSM states are IDLE, RUN, PAUSE and LAP. ss_p has priority: if ss_p and lc_p occur in the same cycle, lc_p is ignored.
  - IDLE: ss_p → RUN. lc_p has no effect.
  - RUN: ss_p → PAUSE. lc_p → LAP, capturing the lap register.
  - LAP: ss_p → PAUSE; the display returns to the live count, which is now stopped. lc_p → RUN, releasing the display.
  - PAUSE: ss_p → RUN. lc_p → IDLE, and the live counter and lap register clear to zero at that edge.
- Counting uses the registered (current) state. A tick_p in the same cycle as RUN→PAUSE is counted. A tick_p in the same cycle as PAUSE→RUN is not counted.

## Timing
- Reset values, all asynchronous:
  - state IDLE
  - all digits and lap register 0
  - synchronizer and history flops 0
  - running=0, lap_active=0, wrap=0
- Reset asserted mid-operation clears everything immediately, with no clock required.
- After reset deasserts, a tick_10 or button that is already high does not produce a pulse until it has been seen low.
- Latency: an input rising before clk edge k is reflected in the state and counter after edge k+SYNC_STAGES. With the default, that is 3 edges.
- wrap is registered. It is high for exactly the one cycle after the edge that loads 00:00.0 from 59:59.9.
- Button pulses are generated once per press regardless of hold length. No debounce is done in this block; btn_ss and btn_lc arrive pre-debounced.
- tick_10 high and low phases must each last at least SYNC_STAGES+1 clk cycles. This is guaranteed by the divider.

## Test plan
- Reset and start:
  - Stimulus: rst pulse, then 25 tick_10 periods with no button press.
  - Required: all digits stay 0 and running=0.
  - Stimulus: then btn_ss press followed by 25 periods.
  - Required: display 00:02.5, running=1.
- Latency:
  - Stimulus: single tick_10 rising edge in RUN.
  - Required: d_ds goes 0→1 exactly 3 clk edges after the input edge. A held-high tick_10 produces only one increment.
- Wrap:
  - Stimulus: run 36000 tick_10 periods from 00:00.0.
  - Required: display returns to 00:00.0, wrap high for exactly one cycle. The check at 35999 periods shows 59:59.9.
- Lap:
  - Stimulus: at 00:12.3 press btn_lc, then 10 more ticks.
  - Required: display holds 00:12.3, lap_active=1.
  - Stimulus: press btn_lc again.
  - Required: display 00:13.3.
- Pause and clear:
  - Stimulus: in RUN press btn_ss, then 5 ticks.
  - Required: count unchanged.
  - Stimulus: press btn_lc.
  - Required: IDLE with display 00:00.0.
  - Stimulus: btn_ss and btn_lc pressed in the same cycle from PAUSE.
  - Required: goes to RUN without clearing.
- Async reset:
  - Stimulus: assert rst mid-count, between clock edges, in LAP.
  - Required: all outputs 0 immediately, and the state is IDLE after release.
